// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with multi-cycle mul/div handshake,
// timeout abort and saturating performance counters.
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_muldiv,
  input  logic             md_done,
  input  logic             mem_redirect,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_start,
  output logic             md_abort,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int TW = $clog2(MD_TIMEOUT + 1);
  typedef enum logic {RUN, MD_WAIT} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic sup, sup_nxt, load_use, timeout;
  assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign timeout = rst && !mem_redirect && state == MD_WAIT && !md_done && tmo == TW'(MD_TIMEOUT - 1);
  always_comb begin
    pc_load = 1'b1;
    if_id_load = 1'b1;
    id_ex_load = 1'b1;
    ex_mem_load = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_flush = 1'b0;
    md_start = 1'b0;
    md_abort = 1'b0;
    state_nxt = state;
    tmo_nxt = tmo;
    sup_nxt = 1'b0;
    if (rst) begin
      if (mem_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_flush = 1'b1;
        md_abort = state == MD_WAIT;
        state_nxt = RUN;
        tmo_nxt = '0;
      end else if (state == MD_WAIT) begin
        pc_load = 1'b0;
        if_id_load = 1'b0;
        id_ex_load = 1'b0;
        if (md_done) begin
          state_nxt = RUN;
          tmo_nxt = '0;
          sup_nxt = 1'b1;
        end else if (timeout) begin
          md_abort = 1'b1;
          id_ex_load = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_flush = 1'b1;
          state_nxt = RUN;
          tmo_nxt = '0;
        end else begin
          ex_mem_flush = 1'b1;
          tmo_nxt = tmo + 1'b1;
        end
      end else if (ex_muldiv && !sup) begin
        // the div stays in ID_EX one more cycle after completion; sup blocks a restart
        md_start = 1'b1;
        pc_load = 1'b0;
        if_id_load = 1'b0;
        id_ex_load = 1'b0;
        ex_mem_flush = !md_done;
        sup_nxt = md_done;
        state_nxt = md_done ? RUN : MD_WAIT;
      end else if (load_use) begin
        pc_load = 1'b0;
        if_id_load = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      tmo <= '0;
      sup <= 1'b0;
      md_err <= 1'b0;
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      tmo <= tmo_nxt;
      sup <= sup_nxt;
      md_err <= md_err | timeout;
      if (!pc_load && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (mem_redirect && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_hazard_ctrl;
  localparam int MDT = 63;
  localparam logic [8:0] DEF = 9'b1111_00000, LU = 9'b0011_01000, ENT = 9'b0001_00110,
                         HOLD = 9'b0001_00100, DONE = 9'b0001_00000, RW = 9'b1111_11101,
                         TO = 9'b0011_01101;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_muldiv = 0, md_done = 0, mem_redirect = 0;
  logic pc_load, if_id_load, id_ex_load, ex_mem_load, if_id_flush, id_ex_flush, ex_mem_flush;
  logic md_start, md_abort, md_err;
  logic [15:0] stall_cycles, flush_count;
  logic b_pc_load, b_if_id_load, b_id_ex_load, b_ex_mem_load, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush;
  logic b_md_start, b_md_abort, b_md_err;
  logic [3:0] b_stall_cycles, b_flush_count;
  int total = 0, bad = 0;
  bit m_wait, m_sup, m_err;
  int m_cnt, m_stall, m_flush;
  wire [8:0] outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, if_id_flush, id_ex_flush,
                     ex_mem_flush, md_start, md_abort};

  hazard_ctrl #(.CNT_W(16), .MD_TIMEOUT(MDT)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
    .md_done(md_done), .mem_redirect(mem_redirect), .pc_load(pc_load), .if_id_load(if_id_load),
    .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .md_start(md_start),
    .md_abort(md_abort), .md_err(md_err), .stall_cycles(stall_cycles), .flush_count(flush_count));

  hazard_ctrl #(.CNT_W(4), .MD_TIMEOUT(MDT)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
    .md_done(md_done), .mem_redirect(mem_redirect), .pc_load(b_pc_load), .if_id_load(b_if_id_load),
    .id_ex_load(b_id_ex_load), .ex_mem_load(b_ex_mem_load), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush), .md_start(b_md_start),
    .md_abort(b_md_abort), .md_err(b_md_err), .stall_cycles(b_stall_cycles), .flush_count(b_flush_count));

  always #5 clk = ~clk;

  function automatic int sat(int v, int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  // expected controls derived from the priority rules: redirect > mul/div > load-use
  function automatic logic [8:0] exp_out();
    logic pl, il, el, ml, fi, fe, fm, st, ab, hit;
    {pl, il, el, ml, fi, fe, fm, st, ab} = DEF;
    hit = ex_mem_read && ex_rd != 0 &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst) return DEF;
    if (mem_redirect) begin
      fi = 1; fe = 1; fm = 1; ab = m_wait;
    end else if (m_wait) begin
      pl = 0; il = 0; el = 0;
      if (!md_done && m_cnt == MDT - 1) begin ab = 1; el = 1; fe = 1; fm = 1; end
      else if (!md_done) fm = 1;
    end else if (ex_muldiv && !m_sup) begin
      st = 1; pl = 0; il = 0; el = 0; fm = !md_done;
    end else if (hit) begin
      pl = 0; il = 0; fe = 1;
    end
    return {pl, il, el, ml, fi, fe, fm, st, ab};
  endfunction

  task automatic step();
    logic [8:0] e;
    bit to, ent;
    e = exp_out();
    to = rst && !mem_redirect && m_wait && !md_done && m_cnt == MDT - 1;
    ent = rst && !mem_redirect && !m_wait && ex_muldiv && !m_sup;
    @(posedge clk);
    if (!rst) begin
      m_wait = 0; m_sup = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[8]) m_stall++;
      if (mem_redirect) m_flush++;
      if (to) m_err = 1;
      if (mem_redirect || to || (m_wait && md_done)) begin
        m_sup = m_wait && md_done && !mem_redirect;
        m_wait = 0; m_cnt = 0;
      end else if (m_wait) m_cnt++;
      else begin
        m_sup = ent && md_done; m_wait = ent && !md_done;
      end
    end
    #1;
  endtask

  task automatic clear_in();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_muldiv, md_done, mem_redirect} = '0;
  endtask

  task automatic do_reset();
    clear_in(); rst = 0; step(); rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      {ex_muldiv, mem_redirect, ex_mem_read, id_uses_rs1} = 4'b1111;
      ex_rd = 5'd3; id_rs1 = 5'd3; md_done = i[0];
      #1;
      total++;
      if (outs !== DEF) begin bad++; $display("FAIL reset_out got=%b exp=%b", outs, DEF); end
      step();
      total++;
      if (md_err !== 0 || stall_cycles !== 0 || flush_count !== 0 || b_stall_cycles !== 0) begin
        bad++; $display("FAIL reset_regs err=%b stall=%0d flush=%0d", md_err, stall_cycles, flush_count);
      end
    end
    clear_in(); rst = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
    #1; total++;
    if (outs !== LU) begin bad++; $display("FAIL lu_rs1 got=%b exp=%b", outs, LU); end
    step(); clear_in(); #1; total++;
    if (outs !== DEF || stall_cycles !== 1) begin
      bad++; $display("FAIL lu_after got=%b stall=%0d exp=%b stall=1", outs, stall_cycles, DEF);
    end
    ex_mem_read = 1; ex_rd = 0; id_uses_rs1 = 1; id_rs1 = 0;
    #1; total++;
    if (outs !== DEF) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", outs, DEF); end
    ex_rd = 5; id_rs1 = 1; id_rs2 = 5; id_uses_rs2 = 0;
    #1; total++;
    if (outs !== DEF) begin bad++; $display("FAIL lu_unused got=%b exp=%b", outs, DEF); end
    id_uses_rs2 = 1;
    #1; total++;
    if (outs !== LU) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", outs, LU); end
    ex_mem_read = 0;
    #1; total++;
    if (outs !== DEF) begin bad++; $display("FAIL lu_noload got=%b exp=%b", outs, DEF); end
    step(); clear_in();
  endtask

  task automatic test_divide();
    int starts = 0;
    logic [8:0] e;
    do_reset();
    ex_muldiv = 1;
    for (int c = 1; c <= 12; c++) begin
      md_done = (c == 11);
      e = c == 1 ? ENT : c == 11 ? DONE : c == 12 ? DEF : HOLD;
      #1; total++;
      if (outs !== e) begin bad++; $display("FAIL div_c%0d got=%b exp=%b", c, outs, e); end
      starts += int'(md_start);
      step();
    end
    clear_in(); #1; total++;
    if (starts !== 1 || stall_cycles !== 11) begin
      bad++; $display("FAIL div_sum starts=%0d stall=%0d exp starts=1 stall=11", starts, stall_cycles);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ex_muldiv = 1; step(); ex_muldiv = 0;
    for (int c = 1; c <= 3; c++) step();
    mem_redirect = 1; #1; total++;
    if (outs !== RW) begin bad++; $display("FAIL redir_wait got=%b exp=%b", outs, RW); end
    step(); clear_in(); #1; total++;
    if (outs !== DEF || flush_count !== 1) begin
      bad++; $display("FAIL redir_after got=%b flush=%0d exp=%b flush=1", outs, flush_count, DEF);
    end
  endtask

  task automatic test_timeout();
    int ab_at = 0;
    do_reset();
    ex_muldiv = 1; step(); ex_muldiv = 0;
    for (int n = 1; n <= 70 && ab_at == 0; n++) begin
      #1;
      if (md_abort) begin
        ab_at = n; total++;
        if (outs !== TO) begin bad++; $display("FAIL tmo_out got=%b exp=%b", outs, TO); end
      end
      step();
    end
    total++;
    if (ab_at !== MDT) begin bad++; $display("FAIL tmo_cycle got=%0d exp=%0d", ab_at, MDT); end
    for (int i = 0; i < 5; i++) begin
      #1; total++;
      if (outs !== DEF || md_err !== 1) begin
        bad++; $display("FAIL tmo_after got=%b err=%b exp=%b err=1", outs, md_err, DEF);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1; ex_rd = 7; id_uses_rs2 = 1; id_rs2 = 7;
    for (int i = 0; i < 20; i++) step();
    clear_in(); #1; total++;
    if (b_stall_cycles !== 4'd15 || stall_cycles !== 20) begin
      bad++; $display("FAIL sat_stall got4=%0d got16=%0d exp 15/20", b_stall_cycles, stall_cycles);
    end
    ex_muldiv = 1; step();
    for (int i = 0; i < 3; i++) step();
    rst = 0; #1; total++;
    if (outs !== DEF) begin bad++; $display("FAIL rst_mid_div got=%b exp=%b", outs, DEF); end
    step(); rst = 1; ex_muldiv = 0; #1; total++;
    if (outs !== DEF || stall_cycles !== 0 || flush_count !== 0 || b_stall_cycles !== 0) begin
      bad++; $display("FAIL rst_after got=%b stall=%0d flush=%0d", outs, stall_cycles, flush_count);
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(99) != 0;
      id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3)); ex_rd = 5'($urandom_range(3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_muldiv = $urandom_range(5) == 0; md_done = $urandom_range(39) == 0;
      mem_redirect = $urandom_range(199) == 0;
      #1; e = exp_out(); total++;
      if (outs !== e) begin bad++; $display("FAIL rnd_out i=%0d got=%b exp=%b", i, outs, e); end
      step(); total++;
      if (md_err !== m_err || stall_cycles !== 16'(sat(m_stall, 16)) || flush_count !== 16'(sat(m_flush, 16)) ||
          b_stall_cycles !== 4'(sat(m_stall, 4)) || b_flush_count !== 4'(sat(m_flush, 4))) begin
        bad++;
        $display("FAIL rnd_regs i=%0d err=%b/%b stall=%0d/%0d flush=%0d/%0d s4=%0d f4=%0d", i, md_err, m_err,
                 stall_cycles, m_stall, flush_count, m_flush, b_stall_cycles, b_flush_count);
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_redirect_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 Parameter MD_TIMEOUT, default 63: maximum number of MD_WAIT cycles before the multiply/divide operation is abandoned.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source register fields of the IF_ID instruction.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  IF_ID instruction reads that source.
REQ-007 ex_rd  in  5  rd field of the ID_EX instruction.
REQ-008 ex_mem_read  in  1  ID_EX instruction is a load (mem_read nonzero).
REQ-009 ex_muldiv  in  1  ID_EX instruction is a multi-cycle M-extension op (div/divu/rem/remu).
REQ-010 md_done  in  1  multi-cycle unit result valid, one-cycle pulse.
REQ-011 mem_redirect  in  1  branch_sel nonzero in MEM; PC target is taken this cycle.
REQ-012 pc_load, if_id_load, id_ex_load, ex_mem_load  out  1 each  register enables.
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a NOP/bubble (all control bits zero) instead of D.
REQ-014 md_start, md_abort  out  1 each  one-cycle pulses to the multi-cycle unit.
REQ-015 md_err  out  1  sticky: timeout occurred.
REQ-016 stall_cycles, flush_count  out  CNT_W each  saturating performance counters.

Function
REQ-017 The block SHALL implement a two-state FSM: RUN and MD_WAIT.
REQ-018 Default in RUN, with no event active: all *_load = 1, all *_flush = 0, and md_start = md_abort = 0.
REQ-019 Priority, highest first: mem_redirect, then muldiv entry, then load-use stall.
REQ-020 Redirect (any state): pc_load = 1; if_id_flush, id_ex_flush and ex_mem_flush = 1; next state RUN; flush_count increments.
REQ-021 Redirect in MD_WAIT SHALL also pulse md_abort the same cycle, and the timeout counter clears.
REQ-022 Load-use in RUN: ex_mem_read = 1, ex_rd != 0, and (id_uses_rs1 and id_rs1 == ex_rd, or id_uses_rs2 and id_rs2 == ex_rd).
REQ-023 Load-use response: pc_load = 0, if_id_load = 0, id_ex_flush = 1, ex_mem_load = 1, for exactly one cycle; no state change.
REQ-024 Muldiv entry: in RUN with ex_muldiv = 1 and no redirect, md_start pulses one cycle; next state MD_WAIT, or RUN if md_done is already 1 that cycle.
REQ-025 Muldiv entry cycle: pc_load, if_id_load, id_ex_load = 0; ex_mem_flush = 1, unless md_done = 1, in which case ex_mem_load = 1 with no flush.
REQ-026 MD_WAIT holding: pc_load, if_id_load, id_ex_load = 0; ex_mem_flush = 1; md_start = 0; timeout counter increments.
REQ-027 md_done in MD_WAIT: ex_mem_load = 1 with no flush; pc/if_id/id_ex loads = 0 that cycle; next state RUN.
REQ-028 The next cycle in RUN SHALL NOT re-issue md_start for the same instruction, enforced by a one-cycle suppress flag set on exit.
REQ-029 Timeout: when the counter reaches MD_TIMEOUT with no md_done, md_abort pulses and md_err sets (sticky until reset).
REQ-030 Timeout response: id_ex_flush = 1, ex_mem_flush = 1, pc/if_id loads = 0; next state RUN.
REQ-031 md_done in RUN (spurious) SHALL be ignored.
REQ-032 stall_cycles increments each cycle pc_load = 0; flush_count increments per redirect cycle; both saturate at all-ones and never wrap.
REQ-033 Outputs SHALL be combinational from state plus inputs; FSM state, timeout counter, suppress flag, md_err and counters SHALL be registered.

Reset
REQ-034 When rst = 0 at a clock edge: state = RUN; timeout counter, suppress flag, md_err, stall_cycles and flush_count = 0.
REQ-035 While rst = 0, outputs SHALL be: all *_load = 1, all *_flush = 0, md_start = md_abort = 0.
REQ-036 Reset asserted in MD_WAIT SHALL return to RUN without pulsing md_abort.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 -> one cycle with pc_load=0, if_id_load=0, id_ex_flush=1; stall_cycles=1.
REQ-038 Load-use, x0 and unused source: ex_rd=0, id_rs1=0 -> no stall; ex_rd=5, id_rs2=5, id_uses_rs2=0 -> no stall.
REQ-039 Divide: ex_muldiv=1, md_done after 10 cycles -> md_start one pulse; 11 stalled cycles; ex_mem_load=1 with no flush on the done cycle; no second md_start.
REQ-040 Redirect in MD_WAIT at cycle 4 -> md_abort=1, all three flushes=1, pc_load=1, state RUN, flush_count=1.
REQ-041 Timeout: md_done never asserted, MD_TIMEOUT=63 -> md_abort at the 63rd MD_WAIT cycle, md_err=1 and held, state RUN.
REQ-042 Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15; rst=0 mid-divide -> counters 0, state RUN, no md_abort.
